// File: rtl/pipe_buf_pkg.sv
// Shared types and width helpers for the pipeline stage buffer.
// The buffer is payload-agnostic; stage payload structs live elsewhere.
package pipe_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ACTIVE = 2'b01,
    FULL   = 2'b10
  } pipe_buf_state_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Handshake, control and status bundle between two datapath stages.
interface pipe_stage_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) ();
  import pipe_buf_pkg::*;

  logic                                  in_valid;
  logic                                  in_ready;
  logic [WIDTH-1:0]                      in_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [WIDTH-1:0]                      out_data;
  logic                                  flush;
  logic                                  hold;
  logic [pipe_buf_pkg::lvl_width(DEPTH)-1:0] level;
  logic                                  almost_full;
  pipe_buf_state_t                       state;

  modport master (
    output in_valid, in_data, out_ready, flush, hold,
    input  in_ready, out_valid, out_data, level, almost_full, state
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, hold,
    output in_ready, out_valid, out_data, level, almost_full, state
  );

endinterface

// File: rtl/pipe_buf_chk.sv
// State-encoding checker: the unused code 2'b11 must fall back to EMPTY.
module pipe_buf_chk (
  input logic       i_clk,
  input logic       i_rst,
  input logic [1:0] i_state
);

  a_illegal_state_recovers: assert property (
    @(posedge i_clk) disable iff (i_rst) (i_state == 2'b11) |=> (i_state == 2'b00)
  );

  c_illegal_state_seen: cover property (
    @(posedge i_clk) disable iff (i_rst) (i_state == 2'b11)
  );

endmodule

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH register array, one write port and one asynchronous read port.
// Contents are deliberately not reset.
module pipe_buf_mem
  import pipe_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_we,
  input  logic [ptr_width(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic [ptr_width(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]            o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic DEPTH-entry pipeline latch with valid/ready on both sides,
// flush, hold (bubble) and optional zero-latency bypass when empty.
module pipe_stage_buffer
  import pipe_buf_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int BYPASS   = 0,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic                CLK,
  input logic                nRST,
  pipe_stage_buffer_if.slave bus
);

  localparam int             PW      = ptr_width(DEPTH);
  localparam int             LW      = lvl_width(DEPTH);
  localparam logic [LW-1:0]  L_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0]  L_AF    = LW'(AF_LEVEL);
  localparam logic           L_BYP   = (BYPASS != 0);

  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  pipe_buf_state_t  r_state;
  pipe_buf_state_t  w_state_nxt;
  logic             w_empty;
  logic             w_out_valid;
  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;
  logic             w_we;
  logic             w_rd_adv;
  logic [WIDTH-1:0] w_rdata;

  // Reset gates both handshakes so nothing is offered or accepted while it is held.
  assign w_empty     = (r_level == LW'(0));
  assign w_out_valid = !nRST && !bus.flush && !bus.hold && (!w_empty || (L_BYP && bus.in_valid));
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_in_ready  = !nRST && !bus.flush && ((r_level < L_DEPTH) || w_pop);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_bypass    = w_empty && w_push && w_pop;
  assign w_we        = w_push && !w_bypass;
  assign w_rd_adv    = w_pop && !w_bypass;

  // Occupancy for the next edge
  always_comb begin
    w_level_nxt = r_level;
    if (bus.flush) begin
      w_level_nxt = LW'(0);
    end else if (w_we && !w_rd_adv) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_we && w_rd_adv) begin
      w_level_nxt = r_level - LW'(1);
    end else begin
      w_level_nxt = r_level;
    end
  end

  // Next state follows the next occupancy; the spare code falls back to EMPTY
  always_comb begin
    w_state_nxt = EMPTY;
    case (r_state)
      EMPTY, ACTIVE, FULL: begin
        if (w_level_nxt == LW'(0)) begin
          w_state_nxt = EMPTY;
        end else if (w_level_nxt == L_DEPTH) begin
          w_state_nxt = FULL;
        end else begin
          w_state_nxt = ACTIVE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_rd_ptr <= PW'(0);
      r_wr_ptr <= PW'(0);
      r_level  <= LW'(0);
    end else if (bus.flush) begin
      r_rd_ptr <= PW'(0);
      r_wr_ptr <= PW'(0);
      r_level  <= LW'(0);
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_level <= w_level_nxt;
    end
  end

  pipe_buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  pipe_buf_chk u_chk (
    .i_clk   (CLK),
    .i_rst   (nRST),
    .i_state (r_state)
  );

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_data    = w_empty ? bus.in_data : w_rdata;
  assign bus.level       = r_level;
  assign bus.almost_full = (r_level >= L_AF);
  assign bus.state       = r_state;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference of the buffer's behaviour.
module tb_pipe_stage_buffer;
  import pipe_buf_pkg::*;

  localparam int W = 32;
  localparam int D = 4;

  logic       CLK  = 1'b0;
  logic       nRST = 1'b1;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [W-1:0] mq [$];

  pipe_stage_buffer_if #(.WIDTH(W), .DEPTH(D)) b0 ();
  pipe_stage_buffer_if #(.WIDTH(W), .DEPTH(D)) b1 ();

  pipe_stage_buffer #(.WIDTH(W), .DEPTH(D), .BYPASS(0), .AF_LEVEL(3)) dut0 (
    .CLK (CLK), .nRST (nRST), .bus (b0));
  pipe_stage_buffer #(.WIDTH(W), .DEPTH(D), .BYPASS(1), .AF_LEVEL(3)) dut1 (
    .CLK (CLK), .nRST (nRST), .bus (b1));

  always #5 CLK = ~CLK;

  // Reference: contents are a FIFO queue; no bypass on the b0 instance
  function automatic logic m_out_valid();
    return !b0.flush && !b0.hold && (mq.size() > 0);
  endfunction

  function automatic logic m_in_ready();
    return !b0.flush && ((mq.size() < D) || (m_out_valid() && b0.out_ready));
  endfunction

  function automatic logic [1:0] m_state();
    if (mq.size() == 0) return 2'b00;
    if (mq.size() == D) return 2'b10;
    return 2'b01;
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic hd);
    b0.in_valid  = iv;
    b0.in_data   = d;
    b0.out_ready = ordy;
    b0.flush     = fl;
    b0.hold      = hd;
    #1;
  endtask

  task automatic tick();
    logic pop, push;
    pop  = m_out_valid() && b0.out_ready;
    push = b0.in_valid && m_in_ready();
    if (b0.flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(b0.in_data);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    b1.in_valid = 1'b1; b1.in_data = 32'h5; b1.out_ready = 1'b1; b1.flush = 1'b0; b1.hold = 1'b0;
    #2;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", b0.in_ready); end
      n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", b0.out_valid); end
      n_checks++; if (b1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_byp_out_valid: got %b want 0", b1.out_valid); end
      n_checks++; if (b0.level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", b0.level); end
      n_checks++; if (b0.state !== EMPTY) begin n_fail++; $display("FAIL rst_state: got %0d want 0", b0.state); end
      @(posedge CLK); #1;
    end
    b1.in_valid = 1'b0; b1.out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK); nRST = 1'b0; #1;
    n_checks++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b want 1", b0.in_ready); end
    @(posedge CLK); #1;
    n_checks++; if (b0.level !== 3'd0) begin n_fail++; $display("FAIL rst_release_level: got %0d want 0", b0.level); end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, vals[k], 1'b0, 1'b0, 1'b0);
      if (k == 0) begin
        n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_nobypass: out_valid got %b want 0", b0.out_valid); end
      end
      n_checks++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want 1", k, b0.in_ready); end
      n_checks++; if (b0.level !== 3'(k)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", k, b0.level, k); end
      n_checks++; if (b0.almost_full !== (k >= 3)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", k, b0.almost_full, (k >= 3)); end
      tick();
    end
    drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    n_checks++; if (b0.level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d want 4", b0.level); end
    n_checks++; if (b0.state !== FULL) begin n_fail++; $display("FAIL full_state: got %0d want 2", b0.state); end
    n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", b0.in_ready); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", k, b0.out_valid); end
      n_checks++; if (b0.out_data !== vals[k]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", k, b0.out_data, vals[k]); end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (b0.state !== EMPTY) begin n_fail++; $display("FAIL drain_state: got %0d want 0", b0.state); end
    n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b want 0", b0.out_valid); end
  endtask

  task automatic test_back_to_back_full();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h11 * (k + 1), 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 32'h55 + 32'(c), 1'b1, 1'b0, 1'b0);
      n_checks++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, b0.in_ready); end
      n_checks++; if (b0.out_data !== mq[0]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", c, b0.out_data, mq[0]); end
      tick();
      n_checks++; if (b0.level !== 3'd4 || b0.state !== FULL) begin n_fail++; $display("FAIL b2b_full[%0d]: level %0d state %0d want 4/2", c, b0.level, b0.state); end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (b0.out_data !== 32'h59) begin n_fail++; $display("FAIL b2b_head: got %h want 59", b0.out_data); end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (b0.out_data !== 32'h59 + 32'(c)) begin n_fail++; $display("FAIL b2b_drain[%0d]: got %h want %h", c, b0.out_data, 32'h59 + 32'(c)); end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
    n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", b0.in_ready); end
    n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", b0.out_valid); end
    tick();
    n_checks++; if (b0.level !== 3'd0 || b0.state !== EMPTY) begin n_fail++; $display("FAIL flush_after: level %0d state %0d want 0/0", b0.level, b0.state); end
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h98, 1'b1, 1'b1, 1'b1);
    tick();
    n_checks++; if (b0.level !== 3'd0) begin n_fail++; $display("FAIL flush_hold: level got %0d want 0", b0.level); end
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 32'h77) begin n_fail++; $display("FAIL flush_first_out: valid %b data %h want 1/77", b0.out_valid, b0.out_data); end
    tick();
  endtask

  task automatic test_hold();
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h1A, 1'b0, 1'b0, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'hB + 32'(c), 1'b1, 1'b0, 1'b1);
      n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 0", c, b0.out_valid); end
      n_checks++; if (b0.in_ready !== (c < 2)) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want %b", c, b0.in_ready, (c < 2)); end
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (b0.level !== 3'd4) begin n_fail++; $display("FAIL hold_level: got %0d want 4", b0.level); end
    n_checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 32'hA) begin n_fail++; $display("FAIL hold_release: valid %b data %h want 1/a", b0.out_valid, b0.out_data); end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_bypass();
    b1.in_valid = 1'b1; b1.in_data = 32'hDEAD; b1.out_ready = 1'b1; #1;
    n_checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 32'hDEAD) begin n_fail++; $display("FAIL byp_pass: valid %b data %h want 1/dead", b1.out_valid, b1.out_data); end
    @(posedge CLK); #1;
    n_checks++; if (b1.level !== 3'd0) begin n_fail++; $display("FAIL byp_level0: got %0d want 0", b1.level); end
    b1.in_data = 32'hBEEF; b1.out_ready = 1'b0; #1;
    n_checks++; if (b1.out_valid !== 1'b1 || b1.out_data !== 32'hBEEF) begin n_fail++; $display("FAIL byp_offer: valid %b data %h want 1/beef", b1.out_valid, b1.out_data); end
    @(posedge CLK); #1;
    n_checks++; if (b1.level !== 3'd1 || b1.state !== ACTIVE) begin n_fail++; $display("FAIL byp_store: level %0d state %0d want 1/1", b1.level, b1.state); end
    b1.in_valid = 1'b0; b1.out_ready = 1'b1; #1;
    n_checks++; if (b1.out_data !== 32'hBEEF) begin n_fail++; $display("FAIL byp_stored_data: got %h want beef", b1.out_data); end
    @(posedge CLK); #1;
    b1.in_valid = 1'b1; b1.in_data = 32'h1234; b1.hold = 1'b1; #1;
    n_checks++; if (b1.out_valid !== 1'b0) begin n_fail++; $display("FAIL byp_hold_valid: got %b want 0", b1.out_valid); end
    @(posedge CLK); #1;
    n_checks++; if (b1.level !== 3'd1) begin n_fail++; $display("FAIL byp_hold_level: got %0d want 1", b1.level); end
    b1.in_valid = 1'b0; b1.hold = 1'b0; b1.flush = 1'b1;
    @(posedge CLK); #1;
    b1.flush = 1'b0; b1.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hC0 + 32'(k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 nRST = 1'b1;
    #1;
    n_checks++; if (b0.level !== 3'd0) begin n_fail++; $display("FAIL arst_level: got %0d want 0", b0.level); end
    n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b want 0", b0.out_valid); end
    mq.delete();
    @(negedge CLK); nRST = 1'b0; #1;
    n_checks++; if (b0.in_ready !== 1'b1 || b0.state !== EMPTY) begin n_fail++; $display("FAIL arst_release: in_ready %b state %0d want 1/0", b0.in_ready, b0.state); end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0));
      n_checks++; if (b0.in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, b0.in_ready, m_in_ready()); end
      n_checks++; if (b0.out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, b0.out_valid, m_out_valid()); end
      if (m_out_valid()) begin
        n_checks++; if (b0.out_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", c, b0.out_data, mq[0]); end
      end
      n_checks++; if (b0.level !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d want %0d", c, b0.level, mq.size()); end
      n_checks++; if (b0.state !== m_state()) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", c, b0.state, m_state()); end
      n_checks++; if (b0.almost_full !== (mq.size() >= 3)) begin n_fail++; $display("FAIL rnd_af[%0d]: got %b want %b", c, b0.almost_full, (mq.size() >= 3)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back_full();
    test_flush();
    test_hold();
    test_bypass();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
